// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexed display scan capture.
// Digit count, BCD width, FSM state type, digit index type, dwell bundle.
package mux_scan_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W    = 4;
  localparam int BCD_MAX    = 9;

  typedef enum logic {
    SYNC,
    COLLECT
  } scan_state_e;

  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] anodos;
    logic [DIGIT_W-1:0]    bcd;
  } dwell_t;

  // Position of the set bit; only meaningful for a one-hot strobe.
  function automatic digit_idx_t onehot_idx(
    input logic [NUM_DIGITS-1:0] a
  );
    digit_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[i]) idx = digit_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_stable_filter.sv
// Input register plus stability counter for the scanned {anodos,bcd} pair.
// Ports: clk, rst_n, anodos_in, bcd_in in; accept pulse and captured dwell out.
module scan_stable_filter
  import mux_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] anodos_in,
  input  logic [DIGIT_W-1:0]    bcd_in,
  output logic                  accept,
  output dwell_t                dwell
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  dwell_t        pair_q, pair_d;
  dwell_t        prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          same;

  always_comb begin
    pair_d = '{anodos: anodos_in, bcd: bcd_in};
    prev_d = pair_q;
    same   = (pair_q == prev_q);
    cnt_d  = cnt_q;
    accept = 1'b0;
    // A change always restarts the count, even on the threshold cycle.
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d  = cnt_q + CW'(1);
      accept = (cnt_q == CW'(STABLE_CYCLES - 1));
    end
  end

  assign dwell = pair_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      pair_q <= pair_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_capture.sv
// Rebuilds the 5-digit M:SS:tt frame from a multiplexed BCD scan.
// Ports: clk, rst_n, anodos_in, bcd_in in; digits_out, frame_valid,
// err_onehot, err_bcd, seq_err, scan_lost out.
// Optional idle watchdog enabled by defining SCAN_TIMEOUT_EN.
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 150_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS-1:0]         anodos_in,
  input  logic [DIGIT_W-1:0]            bcd_in,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
  output logic                          frame_valid,
  output logic                          err_onehot,
  output logic                          err_bcd,
  output logic                          seq_err,
  output logic                          scan_lost
);

  logic   accept;
  dwell_t dwell;

  scan_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .anodos_in(anodos_in),
    .bcd_in   (bcd_in),
    .accept   (accept),
    .dwell    (dwell)
  );

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow_t;

  scan_state_e                   state_q, state_d;
  digit_idx_t                    exp_q, exp_d;
  shadow_t                       shadow_q, shadow_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
  logic                          fv_q, fv_d;
  logic                          eoh_q, eoh_d;
  logic                          ebcd_q, ebcd_d;
  logic                          seq_q, seq_d;
  logic                          lost_q, lost_d;
  logic                          valid_dig;
  digit_idx_t                    idx;

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    shadow_d  = shadow_q;
    digits_d  = digits_q;
    fv_d      = 1'b0;
    eoh_d     = 1'b0;
    ebcd_d    = 1'b0;
    seq_d     = 1'b0;
    lost_d    = lost_q;
    valid_dig = 1'b0;
    idx       = onehot_idx(dwell.anodos);
    if (accept) begin
      if (dwell.anodos == '0) begin
        // blank dwell between digits: ignored
      end else if (!$onehot(dwell.anodos)) begin
        eoh_d   = 1'b1;
        state_d = SYNC;
      end else if (dwell.bcd > DIGIT_W'(BCD_MAX)) begin
        ebcd_d  = 1'b1;
        state_d = SYNC;
      end else begin
        valid_dig     = 1'b1;
        shadow_d[idx] = dwell.bcd;
        if (state_q == SYNC) begin
          if (idx == 3'd0) begin
            state_d = COLLECT;
            exp_d   = 3'd1;
          end
        end else if (idx == exp_q) begin
          if (exp_q == 3'd4) begin
            digits_d = {dwell.bcd, shadow_q[3:0]};
            fv_d     = 1'b1;
            state_d  = SYNC;
          end else begin
            exp_d = exp_q + 3'd1;
          end
        end else begin
          seq_d = 1'b1;
          if (idx == 3'd0) begin
            state_d = COLLECT;
            exp_d   = 3'd1;
          end else begin
            state_d = SYNC;
          end
        end
      end
    end
`ifdef SCAN_TIMEOUT_EN
    to_d = to_q;
    if (valid_dig) begin
      to_d   = '0;
      lost_d = 1'b0;
    end else if (to_q != TW'(TIMEOUT_CYCLES)) begin
      to_d = to_q + TW'(1);
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        lost_d  = 1'b1;
        state_d = SYNC;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      exp_q    <= '0;
      shadow_q <= '0;
      digits_q <= '0;
      fv_q     <= 1'b0;
      eoh_q    <= 1'b0;
      ebcd_q   <= 1'b0;
      seq_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      digits_q <= digits_d;
      fv_q     <= fv_d;
      eoh_q    <= eoh_d;
      ebcd_q   <= ebcd_d;
      seq_q    <= seq_d;
      lost_q   <= lost_d;
    end
  end

`ifdef SCAN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  assign digits_out  = digits_q;
  assign frame_valid = fv_q;
  assign err_onehot  = eoh_q;
  assign err_bcd     = ebcd_q;
  assign seq_err     = seq_q;
  assign scan_lost   = lost_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed testbench for mux_scan_capture.
// Scenario tasks with inline checks; pulse counters sampled on negedge.
module tb_mux_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  anodos_in = '0;
  logic [3:0]  bcd_in = '0;
  logic [19:0] digits_out;
  logic        frame_valid, err_onehot, err_bcd, seq_err, scan_lost;

  int n_pass = 0;
  int n_tot  = 0;
  int fv_n = 0, eoh_n = 0, ebcd_n = 0, seq_n = 0;

  always #5 clk = ~clk;

  mux_scan_capture #(
    .STABLE_CYCLES (16),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anodos_in  (anodos_in),
    .bcd_in     (bcd_in),
    .digits_out (digits_out),
    .frame_valid(frame_valid),
    .err_onehot (err_onehot),
    .err_bcd    (err_bcd),
    .seq_err    (seq_err),
    .scan_lost  (scan_lost)
  );

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_n++;
    if (err_onehot === 1'b1)  eoh_n++;
    if (err_bcd === 1'b1)     ebcd_n++;
    if (seq_err === 1'b1)     seq_n++;
  end

  task automatic dwell(input logic [4:0] a, input logic [3:0] b,
                       input int n);
    @(posedge clk); #1;
    anodos_in = a;
    bcd_in    = b;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic blank(input int n);
    dwell(5'b0, 4'd0, n);
  endtask

  task automatic scan5(input logic [3:0] v0, v1, v2, v3, v4);
    dwell(5'b00001, v0, 50);
    dwell(5'b00010, v1, 50);
    dwell(5'b00100, v2, 50);
    dwell(5'b01000, v3, 50);
    dwell(5'b10000, v4, 50);
    blank(30);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    anodos_in = '0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    chk("rst_digits", digits_out, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_flags", {err_onehot, err_bcd, seq_err}, 0);
    chk("rst_lost", scan_lost, 0);
  endtask

  task automatic test_frame();
    int f0 = fv_n, e0 = eoh_n + ebcd_n + seq_n;
    blank(20);
    scan5(4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
    chk("t1_fv", fv_n - f0, 1);
    chk("t1_digits", digits_out, 20'h12345);
    chk("t1_flags", eoh_n + ebcd_n + seq_n - e0, 0);
  endtask

  task automatic test_short_dwell();
    int f0 = fv_n, s0 = seq_n;
    dwell(5'b00001, 4'd1, 50);
    dwell(5'b00010, 4'd1, 50);
    dwell(5'b00100, 4'd1, 10);
    dwell(5'b01000, 4'd1, 50);
    dwell(5'b10000, 4'd1, 50);
    blank(30);
    chk("t2_seq", seq_n - s0, 1);
    chk("t2_fv", fv_n - f0, 0);
    chk("t2_digits", digits_out, 20'h12345);
  endtask

  task automatic test_onehot();
    int f0 = fv_n, o0 = eoh_n;
    dwell(5'b00001, 4'd6, 50);
    dwell(5'b00110, 4'd6, 40);
    blank(30);
    chk("t3_eoh", eoh_n - o0, 1);
    chk("t3_hold", digits_out, 20'h12345);
    scan5(4'd9, 4'd8, 4'd7, 4'd6, 4'd5);
    chk("t3_fv", fv_n - f0, 1);
    chk("t3_digits", digits_out, 20'h56789);
  endtask

  task automatic test_bad_bcd();
    int f0 = fv_n, b0 = ebcd_n, s0 = seq_n;
    dwell(5'b00001, 4'd1, 50);
    dwell(5'b00010, 4'hF, 50);
    blank(30);
    chk("t4_ebcd", ebcd_n - b0, 1);
    chk("t4_hold", digits_out, 20'h56789);
    scan5(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    chk("t4_fv", fv_n - f0, 1);
    chk("t4_digits", digits_out, 20'h43210);
    chk("t4_seq", seq_n - s0, 0);
  endtask

  task automatic test_late_start();
    int f0, s0;
    do_reset();
    f0 = fv_n;
    s0 = seq_n;
    dwell(5'b01000, 4'd7, 50);
    dwell(5'b10000, 4'd7, 50);
    chk("t5_nofv", fv_n - f0, 0);
    chk("t5_zero", digits_out, 0);
    scan5(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    chk("t5_fv", fv_n - f0, 1);
    chk("t5_digits", digits_out, 20'h54321);
    chk("t5_seq", seq_n - s0, 0);
  endtask

  task automatic test_reset_mid();
    int f0;
    dwell(5'b00001, 4'd8, 50);
    dwell(5'b00010, 4'd8, 50);
    dwell(5'b00100, 4'd8, 50);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t7_digits", digits_out, 0);
    chk("t7_pulses", {frame_valid, err_onehot, err_bcd, seq_err}, 0);
    anodos_in = '0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    f0 = fv_n;
    blank(20);
    scan5(4'd3, 4'd3, 4'd3, 4'd3, 4'd3);
    chk("t7_fv", fv_n - f0, 1);
    chk("t7_frame", digits_out, 20'h33333);
  endtask

  task automatic test_timeout();
    blank(250);
    @(negedge clk);
`ifdef SCAN_TIMEOUT_EN
    chk("t6_lost", scan_lost, 1);
`else
    chk("t6_nolost", scan_lost, 0);
`endif
    dwell(5'b00001, 4'd2, 50);
    @(negedge clk);
    chk("t6_clear", scan_lost, 0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_short_dwell();
    test_onehot();
    test_bad_bcd();
    test_late_start();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
